alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/cpu_types_pkg.sv | 15 +
 rtl/alu_arbiter.sv | 133 +++++++++++++
 tb/tb_alu_arbiter.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions: the ALU operation encoding used by the ALU and its arbiter.
package cpu_types_pkg;

   typedef enum logic [3:0] {
      ALU_ADD = 4'd0,
      ALU_SUB = 4'd1,
      ALU_AND = 4'd2,
      ALU_OR  = 4'd3,
      ALU_XOR = 4'd4,
      ALU_SLL = 4'd5,
      ALU_SRL = 4'd6,
      ALU_SLT = 4'd7
   } aluop_t;

endpackage

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared combinational ALU (IDLE -> EXEC -> RESP).
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin contention; default is fixed priority to requester 0.
module alu_arbiter
   import cpu_types_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RST,

   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  aluop_t           req_aluop0,
   input  aluop_t           req_aluop1,
   input  logic [WIDTH-1:0] req_porta0,
   input  logic [WIDTH-1:0] req_portb0,
   input  logic [WIDTH-1:0] req_porta1,
   input  logic [WIDTH-1:0] req_portb1,

   output logic [1:0]       resp_valid,
   input  logic [1:0]       resp_ready,
   output logic [WIDTH-1:0] resp_out,
   output logic [2:0]       resp_flags,

   output aluop_t           alu_aluop,
   output logic [WIDTH-1:0] alu_porta,
   output logic [WIDTH-1:0] alu_portb,
   input  logic [WIDTH-1:0] alu_outport,
   input  logic             alu_zero_f,
   input  logic             alu_neg_f,
   input  logic             alu_over_f,

   output logic             busy
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t           state_q;
   aluop_t           op_q;
   logic [WIDTH-1:0] opa_q;
   logic [WIDTH-1:0] opb_q;
   logic [WIDTH-1:0] result_q;
   logic [2:0]       flags_q;
   logic             grant_q;
   logic [1:0]       resp_valid_q;
   logic             busy_q;

   logic             sel;
   logic [1:0]       sel_oh;
   logic             xfer;

`ifdef ALU_ARB_ROUND_ROBIN_EN
   logic             last_grant_q;

   always_comb begin
      if (req_valid == 2'b11) begin
         sel = ~last_grant_q;
      end else begin
         sel = (req_valid == 2'b10);
      end
   end
`else
   always_comb begin
      sel = (req_valid == 2'b10);
   end
`endif

   assign sel_oh    = (req_valid == 2'b00) ? 2'b00 : (sel ? 2'b10 : 2'b01);
   // Ready is forced low during reset so nothing is accepted in the reset cycle.
   assign req_ready = (state_q == IDLE && !RST) ? sel_oh : 2'b00;
   assign xfer      = |(req_valid & req_ready);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= IDLE;
         op_q         <= ALU_ADD;
         opa_q        <= '0;
         opb_q        <= '0;
         result_q     <= '0;
         flags_q      <= 3'b000;
         grant_q      <= 1'b0;
         resp_valid_q <= 2'b00;
         busy_q       <= 1'b0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
         last_grant_q <= 1'b1;
`endif
      end else begin
         unique case (state_q)
            IDLE: begin
               if (xfer) begin
                  op_q    <= sel ? req_aluop1 : req_aluop0;
                  opa_q   <= sel ? req_porta1 : req_porta0;
                  opb_q   <= sel ? req_portb1 : req_portb0;
                  grant_q <= sel;
`ifdef ALU_ARB_ROUND_ROBIN_EN
                  last_grant_q <= sel;
`endif
                  busy_q  <= 1'b1;
                  state_q <= EXEC;
               end
            end
            EXEC: begin
               result_q     <= alu_outport;
               flags_q      <= {alu_over_f, alu_neg_f, alu_zero_f};
               resp_valid_q <= grant_q ? 2'b10 : 2'b01;
               state_q      <= RESP;
            end
            RESP: begin
               // Only the granted requester's ready can release the result.
               if (resp_ready[grant_q]) begin
                  resp_valid_q <= 2'b00;
                  busy_q       <= 1'b0;
                  state_q      <= IDLE;
               end
            end
            default: begin
               resp_valid_q <= 2'b00;
               busy_q       <= 1'b0;
               state_q      <= IDLE;
            end
         endcase
      end
   end

   assign resp_valid = resp_valid_q;
   assign resp_out   = result_q;
   assign resp_flags = flags_q;
   assign busy       = busy_q;
   assign alu_aluop  = op_q;
   assign alu_porta  = opa_q;
   assign alu_portb  = opb_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU, table-driven single ops, and hand sequences for
// contention, backpressure and mid-operation reset, with a scoreboard of expected responses.
module tb_alu_arbiter;
   import cpu_types_pkg::*;

   localparam int W = 32;

   logic          CLK = 1'b0;
   logic          RST;
   logic [1:0]    req_valid;
   logic [1:0]    req_ready;
   aluop_t        req_aluop0, req_aluop1;
   logic [W-1:0]  req_porta0, req_portb0, req_porta1, req_portb1;
   logic [1:0]    resp_valid;
   logic [1:0]    resp_ready;
   logic [W-1:0]  resp_out;
   logic [2:0]    resp_flags;
   aluop_t        alu_aluop;
   logic [W-1:0]  alu_porta, alu_portb, alu_outport;
   logic          alu_zero_f, alu_neg_f, alu_over_f;
   logic          busy;

   typedef struct {
      int           idx;
      aluop_t       op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] out;
      logic [2:0]   flags;
   } vec_t;

   typedef struct {
      logic [1:0]   vld;
      logic [W-1:0] out;
      logic [2:0]   flags;
   } exp_t;

   vec_t vecs [8];
   exp_t sb [$];
   int   pass_cnt = 0;
   int   total_cnt = 0;

   always #5 CLK = ~CLK;

   alu_arbiter #(.WIDTH(W)) dut (
      .CLK         (CLK),
      .RST         (RST),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_aluop0  (req_aluop0),
      .req_aluop1  (req_aluop1),
      .req_porta0  (req_porta0),
      .req_portb0  (req_portb0),
      .req_porta1  (req_porta1),
      .req_portb1  (req_portb1),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .resp_out    (resp_out),
      .resp_flags  (resp_flags),
      .alu_aluop   (alu_aluop),
      .alu_porta   (alu_porta),
      .alu_portb   (alu_portb),
      .alu_outport (alu_outport),
      .alu_zero_f  (alu_zero_f),
      .alu_neg_f   (alu_neg_f),
      .alu_over_f  (alu_over_f),
      .busy        (busy)
   );

   // Behavioural shared ALU.
   always_comb begin
      logic [W-1:0] r;
      r          = '0;
      alu_over_f = 1'b0;
      case (alu_aluop)
         ALU_ADD: begin
            r          = alu_porta + alu_portb;
            alu_over_f = (alu_porta[W-1] == alu_portb[W-1]) && (r[W-1] != alu_porta[W-1]);
         end
         ALU_SUB: begin
            r          = alu_porta - alu_portb;
            alu_over_f = (alu_porta[W-1] != alu_portb[W-1]) && (r[W-1] != alu_porta[W-1]);
         end
         ALU_AND: r = alu_porta & alu_portb;
         ALU_OR:  r = alu_porta | alu_portb;
         ALU_XOR: r = alu_porta ^ alu_portb;
         default: r = '0;
      endcase
      alu_outport = r;
      alu_zero_f  = (r == '0);
      alu_neg_f   = r[W-1];
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_resp(output int n);
      n = 0;
      do begin
         @(posedge CLK);
         #1;
         n++;
      end while (resp_valid == 2'b00 && n < 8);
      check("resp_arrives", 64'(resp_valid != 2'b00), 64'd1);
   endtask

   task automatic compare_resp(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         total_cnt++;
         $display("FAIL %s_sb_empty: got response %b, expected none", tag, resp_valid);
      end else begin
         e = sb.pop_front();
         check({tag, "_resp_valid"}, 64'(resp_valid), 64'(e.vld));
         check({tag, "_resp_out"},   64'(resp_out),   64'(e.out));
         check({tag, "_resp_flags"}, 64'(resp_flags), 64'(e.flags));
      end
   endtask

   task automatic run_op(input int idx, input aluop_t op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] eo, input logic [2:0] ef);
      logic [1:0] oh;
      int         n;
      oh = (idx == 0) ? 2'b01 : 2'b10;
      if (idx == 0) begin
         req_aluop0 = op; req_porta0 = a; req_portb0 = b;
      end else begin
         req_aluop1 = op; req_porta1 = a; req_portb1 = b;
      end
      req_valid = oh;
      #1;
      check("idle_req_ready", 64'(req_ready), 64'(oh));
      sb.push_back('{oh, eo, ef});
      @(posedge CLK);
      #1;
      req_valid = 2'b00;
      check("exec_resp_valid", 64'(resp_valid), 64'd0);
      check("exec_busy", 64'(busy), 64'd1);
      check("exec_req_ready", 64'(req_ready), 64'd0);
      wait_resp(n);
      check("resp_latency", 64'(n), 64'd1);
      compare_resp("op");
      resp_ready = oh;
      @(posedge CLK);
      #1;
      resp_ready = 2'b00;
      check("back_idle_busy", 64'(busy), 64'd0);
      check("back_idle_resp_valid", 64'(resp_valid), 64'd0);
   endtask

   task automatic do_reset();
      req_valid  = 2'b00;
      resp_ready = 2'b00;
      RST        = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      int         n;
      logic [1:0] eg;

      vecs[0] = '{0, ALU_ADD, 32'd5,          32'd7,          32'd12,         3'b000};
      vecs[1] = '{1, ALU_ADD, 32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  3'b110};
      vecs[2] = '{0, ALU_SUB, 32'd3,          32'd3,          32'd0,          3'b001};
      vecs[3] = '{1, ALU_OR,  32'd0,          32'd0,          32'd0,          3'b001};
      vecs[4] = '{0, ALU_AND, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000,  3'b010};
      vecs[5] = '{1, ALU_XOR, 32'hFFFF_FFFF,  32'h0000_FFFF,  32'hFFFF_0000,  3'b010};
      vecs[6] = '{0, ALU_SUB, 32'd0,          32'd1,          32'hFFFF_FFFF,  3'b010};
      vecs[7] = '{1, ALU_SUB, 32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  3'b100};

      req_aluop0 = ALU_ADD; req_porta0 = 32'd9; req_portb0 = 32'd9;
      req_aluop1 = ALU_ADD; req_porta1 = 32'd9; req_portb1 = 32'd9;
      resp_ready = 2'b00;

      // Reset state, with a request pending so ready must be masked.
      RST       = 1'b1;
      req_valid = 2'b01;
      repeat (2) @(posedge CLK);
      #1;
      check("rst_req_ready",  64'(req_ready),  64'd0);
      check("rst_resp_valid", 64'(resp_valid), 64'd0);
      check("rst_resp_out",   64'(resp_out),   64'd0);
      check("rst_resp_flags", 64'(resp_flags), 64'd0);
      check("rst_busy",       64'(busy),       64'd0);
      check("rst_alu_aluop",  64'(alu_aluop),  64'd0);
      check("rst_alu_porta",  64'(alu_porta),  64'd0);
      check("rst_alu_portb",  64'(alu_portb),  64'd0);
      req_valid = 2'b00;
      RST       = 1'b0;
      @(posedge CLK);
      #1;

      for (int i = 0; i < 8; i++) begin
         run_op(vecs[i].idx, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].out, vecs[i].flags);
      end

      // Contention: both held valid across four operations.
      do_reset();
      req_aluop0 = ALU_SUB; req_porta0 = 32'd3; req_portb0 = 32'd3;
      req_aluop1 = ALU_OR;  req_porta1 = 32'd0; req_portb1 = 32'd0;
      req_valid  = 2'b11;
      for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
         eg = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
         eg = 2'b01;
`endif
         #1;
         check("cont_grant", 64'(req_ready), 64'(eg));
         sb.push_back('{eg, 32'd0, 3'b001});
         @(posedge CLK);
         #1;
         check("cont_exec_req_ready", 64'(req_ready), 64'd0);
         wait_resp(n);
         compare_resp("cont");
         check("cont_resp_req_ready", 64'(req_ready), 64'd0);
         resp_ready = eg;
         @(posedge CLK);
         #1;
         resp_ready = 2'b00;
      end
      req_valid = 2'b00;
      @(posedge CLK);
      #1;

      // Backpressure in RESP, with the other requester waiting.
      req_aluop0 = ALU_ADD; req_porta0 = 32'd10; req_portb0 = 32'd20;
      req_valid  = 2'b01;
      #1;
      sb.push_back('{2'b01, 32'd30, 3'b000});
      @(posedge CLK);
      #1;
      req_valid = 2'b11;
      wait_resp(n);
      compare_resp("bp");
      for (int c = 0; c < 6; c++) begin
         // Last cycle drives only the non-granted ready, which must be ignored.
         resp_ready = (c == 5) ? 2'b10 : 2'b00;
         @(posedge CLK);
         #1;
         check("bp_resp_valid", 64'(resp_valid), 64'd1);
         check("bp_resp_out",   64'(resp_out),   64'd30);
         check("bp_req_ready",  64'(req_ready),  64'd0);
         check("bp_busy",       64'(busy),       64'd1);
      end
      req_valid  = 2'b00;
      resp_ready = 2'b01;
      @(posedge CLK);
      #1;
      resp_ready = 2'b00;
      check("bp_release_busy",       64'(busy),       64'd0);
      check("bp_release_resp_valid", 64'(resp_valid), 64'd0);

      // Reset while in EXEC discards the operation.
      req_aluop0 = ALU_ADD; req_porta0 = 32'd1; req_portb0 = 32'd2;
      req_valid  = 2'b01;
      @(posedge CLK);
      #1;
      check("mid_in_exec", 64'(busy), 64'd1);
      RST = 1'b1;
      @(posedge CLK);
      #1;
      check("mid_rst_req_ready",  64'(req_ready),  64'd0);
      check("mid_rst_resp_valid", 64'(resp_valid), 64'd0);
      check("mid_rst_busy",       64'(busy),       64'd0);
      check("mid_rst_alu_porta",  64'(alu_porta),  64'd0);
      req_valid = 2'b00;
      RST       = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(posedge CLK);
         #1;
         check("mid_no_resp", 64'(resp_valid), 64'd0);
      end
      run_op(0, ALU_ADD, 32'd100, 32'd23, 32'd123, 3'b000);

      check("sb_drained", 64'(sb.size()), 64'd0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
